// File: rtl/pcss_link_rx_if.sv
// AXI-stream beat bus carried from the PCSS link receiver toward the host.
interface pcss_link_rx_if #(
  parameter int unsigned DATA_WIDTH = 64
) ();
  logic [DATA_WIDTH-1:0]   tdata;
  logic                    tvalid;
  logic                    tlast;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tready;

  modport master (output tdata, output tvalid, output tlast, output tkeep, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tkeep, output tready);
endinterface

// File: rtl/pcss_link_rx.sv
// PCSS chip-link receive endpoint: parity check, MSB-first word packing into AXIS beats,
// idle-timeout flush of partial beats, and a show-ahead beat FIFO toward the host.
module pcss_link_rx #(
  parameter int unsigned CHIPDATA_WIDTH = 16,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned IDLE_TO        = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHIPDATA_WIDTH-1:0] recv_data_in,
  input  logic                      recv_data_valid,
  input  logic                      recv_data_par,
  output logic                      recv_data_ready,
  output logic                      recv_data_err,
  pcss_link_rx_if.master            m_axis,
  output logic [15:0]               err_cnt
);

  localparam int unsigned WPB    = DATA_WIDTH / CHIPDATA_WIDTH;
  localparam int unsigned KEEP_W = DATA_WIDTH / 8;
  localparam int unsigned BPW    = CHIPDATA_WIDTH / 8;
  localparam int unsigned WC_W   = $clog2(WPB + 1);
  localparam int unsigned IC_W   = $clog2(IDLE_TO + 1);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_W-1:0]     keep;
    logic                  last;
  } entry_t;

  logic [DATA_WIDTH-1:0] asm_q, asm_d;
  logic [WC_W-1:0]       word_cnt_q, word_cnt_d;
  logic [IC_W-1:0]       idle_cnt_q, idle_cnt_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic [15:0]           err_cnt_q, err_cnt_d;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  entry_t                mem_q [FIFO_DEPTH];
  entry_t                push_entry, rd_entry;
  logic [KEEP_W-1:0]     flush_keep;
  logic                  accept, par_ok, good, bad;
  logic                  push, pop, full, empty;

  assign accept = recv_data_valid && ready_q;
  assign par_ok = (recv_data_par == ^recv_data_in);
  assign good   = accept && par_ok;
  assign bad    = accept && !par_ok;

  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign pop   = !empty && m_axis.tready;

  // Top BPW*word_cnt bytes are valid in a partial beat.
  always_comb begin
    flush_keep = '0;
    for (int unsigned i = 0; i < KEEP_W; i++) begin
      if (i < int'(word_cnt_q) * BPW) flush_keep[KEEP_W-1-i] = 1'b1;
    end
  end

  always_comb begin
    asm_d      = asm_q;
    word_cnt_d = word_cnt_q;
    idle_cnt_d = idle_cnt_q;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;
    push       = 1'b0;
    push_entry = '0;
    if (good) begin
      asm_d[(DATA_WIDTH - CHIPDATA_WIDTH) - int'(word_cnt_q) * CHIPDATA_WIDTH +: CHIPDATA_WIDTH]
          = recv_data_in;
      idle_cnt_d = '0;
      if (word_cnt_q == WC_W'(WPB - 1)) begin
        push            = 1'b1;
        push_entry.data = asm_d;
        push_entry.keep = '1;
        push_entry.last = 1'b0;
        asm_d           = '0;
        word_cnt_d      = '0;
      end else begin
        word_cnt_d = word_cnt_q + 1'b1;
      end
    end else if (bad) begin
      asm_d      = '0;
      word_cnt_d = '0;
      idle_cnt_d = '0;
      err_d      = 1'b1;
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end else if (word_cnt_q != '0) begin
      if (idle_cnt_q == IC_W'(IDLE_TO)) begin
        // A full FIFO holds the flush; ready is already low so no word can race it.
        if (!full) begin
          push            = 1'b1;
          push_entry.data = asm_q;
          push_entry.keep = flush_keep;
          push_entry.last = 1'b1;
          asm_d           = '0;
          word_cnt_d      = '0;
          idle_cnt_d      = '0;
        end
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  // One spare slot absorbs the word accepted in the cycle ready falls.
  assign ready_d = (count_d <= CNT_W'(FIFO_DEPTH - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q      <= '0;
      word_cnt_q <= '0;
      idle_cnt_q <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      asm_q      <= asm_d;
      word_cnt_q <= word_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      count_q    <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign rd_entry = mem_q[rd_ptr_q];

  assign m_axis.tvalid   = !empty;
  assign m_axis.tdata    = empty ? '0 : rd_entry.data;
  assign m_axis.tkeep    = empty ? '0 : rd_entry.keep;
  assign m_axis.tlast    = empty ? 1'b0 : rd_entry.last;
  assign recv_data_ready = ready_q;
  assign recv_data_err   = err_q;
  assign err_cnt         = err_cnt_q;

endmodule

// File: tb/tb_pcss_link_rx.sv
// Scoreboard bench for pcss_link_rx: directed link words, expected beats queued at issue time.
module tb_pcss_link_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] recv_data_in;
  logic        recv_data_valid;
  logic        recv_data_par;
  logic        recv_data_ready;
  logic        recv_data_err;
  logic [15:0] err_cnt;

  pcss_link_rx_if #(.DATA_WIDTH(64)) m_axis ();

  pcss_link_rx #(
    .CHIPDATA_WIDTH(16),
    .DATA_WIDTH    (64),
    .FIFO_DEPTH    (8),
    .IDLE_TO       (32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .recv_data_in   (recv_data_in),
    .recv_data_valid(recv_data_valid),
    .recv_data_par  (recv_data_par),
    .recv_data_ready(recv_data_ready),
    .recv_data_err  (recv_data_err),
    .m_axis         (m_axis),
    .err_cnt        (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int    n_tests = 0;
  int    n_fail  = 0;

  function automatic beat_t mk(input logic [63:0] d, input logic [7:0] k, input logic l);
    beat_t b;
    b.data = d;
    b.keep = k;
    b.last = l;
    return b;
  endfunction

  function automatic logic [15:0] wd(input int b, input int i, input logic [7:0] pfx);
    logic [15:0] r;
    r = {pfx, 4'(b), 4'(i)};
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Offers one word and waits (bounded) until it is accepted; returns at posedge+1.
  task automatic send(input logic [15:0] d, input logic bad);
    logic acc;
    int   waited;
    recv_data_in    = d;
    recv_data_par   = bad ? ~(^d) : (^d);
    recv_data_valid = 1'b1;
    acc    = 1'b0;
    waited = 0;
    while (!acc && waited < 300) begin
      acc = recv_data_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    recv_data_valid = 1'b0;
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: word %h not accepted, expected acceptance", d);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && m_axis.tvalid && m_axis.tready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected: got %h/%h/%b, expected no beat",
                 m_axis.tdata, m_axis.tkeep, m_axis.tlast);
      end else begin
        mon_e = exp_q.pop_front();
        if (m_axis.tdata !== mon_e.data || m_axis.tkeep !== mon_e.keep ||
            m_axis.tlast !== mon_e.last) begin
          n_fail++;
          $display("FAIL beat: got %h/%h/%b, expected %h/%h/%b", m_axis.tdata, m_axis.tkeep,
                   m_axis.tlast, mon_e.data, mon_e.keep, mon_e.last);
        end
      end
    end
  end

  initial begin
    rst_n           = 1'b0;
    recv_data_in    = '0;
    recv_data_valid = 1'b0;
    recv_data_par   = 1'b0;
    m_axis.tready   = 1'b0;
    #1;
    check("rst_tvalid", 64'(m_axis.tvalid), 64'd0);
    check("rst_ready", 64'(recv_data_ready), 64'd0);
    check("rst_err", 64'(recv_data_err), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_tkeep_tlast", {55'd0, m_axis.tkeep, m_axis.tlast}, 64'd0);
    #21;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", 64'(recv_data_ready), 64'd1);

    // Full beat, latency one cycle after the 4th word.
    m_axis.tready = 1'b1;
    exp_q.push_back(mk(64'h1111_2222_3333_4444, 8'hFF, 1'b0));
    send(16'h1111, 1'b0);
    send(16'h2222, 1'b0);
    send(16'h3333, 1'b0);
    send(16'h4444, 1'b0);
    check("full_beat_latency", 64'(m_axis.tvalid), 64'd1);
    check("err_cnt_clean", 64'(err_cnt), 64'd0);
    idle(3);

    // Two-word idle flush at idle_cnt == IDLE_TO.
    exp_q.push_back(mk(64'hAAAA_BBBB_0000_0000, 8'hF0, 1'b1));
    send(16'hAAAA, 1'b0);
    send(16'hBBBB, 1'b0);
    idle(32);
    check("flush_not_early", 64'(m_axis.tvalid), 64'd0);
    idle(1);
    check("flush_on_time", 64'(m_axis.tvalid), 64'd1);
    idle(10);

    // Parity error discards partial assembly.
    send(16'h1234, 1'b0);
    send(16'h0001, 1'b1);
    check("err_pulse", 64'(recv_data_err), 64'd1);
    check("err_cnt_1", 64'(err_cnt), 64'd1);
    exp_q.push_back(mk(64'h5678_9ABC_DEF0_1357, 8'hFF, 1'b0));
    send(16'h5678, 1'b0);
    check("err_one_cycle", 64'(recv_data_err), 64'd0);
    send(16'h9ABC, 1'b0);
    send(16'hDEF0, 1'b0);
    send(16'h1357, 1'b0);
    send(16'hFFFF, 1'b1);
    check("err_b2b_1", 64'(recv_data_err), 64'd1);
    send(16'h0F0F, 1'b1);
    check("err_b2b_2", 64'(recv_data_err), 64'd1);
    check("err_cnt_3", 64'(err_cnt), 64'd3);
    idle(1);
    check("err_cleared", 64'(recv_data_err), 64'd0);
    idle(5);

    // Backpressure: 7 beats queued drops ready, then drain all 8 in order.
    m_axis.tready = 1'b0;
    for (int b = 0; b < 7; b++) begin
      exp_q.push_back(mk({wd(b, 0, 8'hC0), wd(b, 1, 8'hC0), wd(b, 2, 8'hC0), wd(b, 3, 8'hC0)},
                         8'hFF, 1'b0));
      for (int i = 0; i < 4; i++) send(wd(b, i, 8'hC0), 1'b0);
    end
    check("bp_ready_low", 64'(recv_data_ready), 64'd0);
    check("bp_tvalid_held", 64'(m_axis.tvalid), 64'd1);
    check("bp_head_stable", m_axis.tdata, 64'hC000_C001_C002_C003);
    exp_q.push_back(mk({wd(7, 0, 8'hC0), wd(7, 1, 8'hC0), wd(7, 2, 8'hC0), wd(7, 3, 8'hC0)},
                       8'hFF, 1'b0));
    m_axis.tready = 1'b1;
    for (int i = 0; i < 4; i++) send(wd(7, i, 8'hC0), 1'b0);
    idle(15);
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // 4th word lands on the timeout edge: word wins, no flush.
    exp_q.push_back(mk(64'h0101_0202_0303_0404, 8'hFF, 1'b0));
    send(16'h0101, 1'b0);
    send(16'h0202, 1'b0);
    send(16'h0303, 1'b0);
    idle(32);
    send(16'h0404, 1'b0);
    idle(45);
    check("prio_no_flush", 64'(exp_q.size()), 64'd0);

    // Single-word flush into a nearly full FIFO with the host stalled.
    m_axis.tready = 1'b0;
    for (int b = 0; b < 6; b++) begin
      exp_q.push_back(mk({wd(b, 0, 8'hD0), wd(b, 1, 8'hD0), wd(b, 2, 8'hD0), wd(b, 3, 8'hD0)},
                         8'hFF, 1'b0));
      for (int i = 0; i < 4; i++) send(wd(b, i, 8'hD0), 1'b0);
    end
    exp_q.push_back(mk(64'hE1E1_0000_0000_0000, 8'hC0, 1'b1));
    send(16'hE1E1, 1'b0);
    idle(40);
    check("flush_near_full_ready", 64'(recv_data_ready), 64'd0);
    m_axis.tready = 1'b1;
    idle(15);
    check("flush_c0_drained", 64'(exp_q.size()), 64'd0);

    // Reset with 3 beats queued and 2 words assembled.
    m_axis.tready = 1'b0;
    for (int k = 0; k < 14; k++) send(wd(k / 4, k % 4, 8'hB0), 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_tvalid", 64'(m_axis.tvalid), 64'd0);
    check("midrst_ready", 64'(recv_data_ready), 64'd0);
    check("midrst_err_cnt", 64'(err_cnt), 64'd0);
    check("midrst_err", 64'(recv_data_err), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_axis.tready = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_midrst", 64'(recv_data_ready), 64'd1);
    exp_q.push_back(mk(64'h7777_8888_9999_AAAA, 8'hFF, 1'b0));
    send(16'h7777, 1'b0);
    send(16'h8888, 1'b0);
    send(16'h9999, 1'b0);
    send(16'hAAAA, 1'b0);
    idle(60);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
